// File: rtl/if_id.sv
// rtl/if_id.sv - two-entry fetch/decode instruction queue
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

module if_id #(
  parameter logic [`INST_WIDTH-1:0] NOP_INST = 32'h00000013
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [`INST_ADDR_WIDTH-1:0] pc_i,
  input  logic [`INST_WIDTH-1:0]      inst_i,
  input  logic                        inst_valid_i,
  output logic                        ready_o,
  input  logic                        hold_i,
  input  logic                        flush_i,
  output logic [`INST_ADDR_WIDTH-1:0] pc_o,
  output logic [`INST_WIDTH-1:0]      inst_o,
  output logic                        valid_o
);

  logic [`INST_ADDR_WIDTH-1:0] slot_pc   [2];
  logic [`INST_WIDTH-1:0]      slot_inst [2];
  logic                        wptr;
  logic                        rptr;
  logic [1:0]                  count;
  logic                        enq;
  logic                        deq;

  // ready depends only on registered occupancy, so hold/flush never reach the pc stage combinationally
  assign ready_o = (count != 2'd2);
  assign valid_o = (count != 2'd0);

  // a full queue refuses new entries even if the head leaves this same edge
  assign enq = inst_valid_i & ready_o & ~flush_i;
  assign deq = valid_o & ~hold_i & ~flush_i;

  // head entry to decode; an empty queue presents a bubble
  always_comb begin
    pc_o   = '0;
    inst_o = NOP_INST;
    if (valid_o) begin
      pc_o   = slot_pc[rptr];
      inst_o = slot_inst[rptr];
    end
  end

  // pointer and occupancy bookkeeping; flush wins over hold and enqueue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush_i) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (enq) wptr <= ~wptr;
      if (deq) rptr <= ~rptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // entry storage, written at the write pointer on an accepted enqueue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_pc[0]   <= '0;
      slot_pc[1]   <= '0;
      slot_inst[0] <= NOP_INST;
      slot_inst[1] <= NOP_INST;
    end else if (enq) begin
      slot_pc[wptr]   <= pc_i;
      slot_inst[wptr] <= inst_i;
    end
  end

endmodule
